// File: rtl/log_mul_feeder.sv
// Control and issue stage for the log-scale float16 multiplier: streams LUT beats in, then issues tagged operand pairs.
// Optional build macro LOG_MUL_FEEDER_LUT_CHECKSUM_EN adds the lut_checksum port and lut_err checking.
module log_mul_feeder #(
    parameter int FLOAT_LEN = 16,
    parameter int MANT_LEN  = 10,
    parameter int LUT_SIZE  = 128,
    parameter int MUL_LAT   = 4,
    parameter int TAG_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [MANT_LEN-1:0]  src_log2,
    input  logic [FLOAT_LEN-1:0] src_exp2,
    output logic                 lut_wr_en,
    output logic [MANT_LEN-1:0]  log2_lut_data_out,
    output logic [FLOAT_LEN-1:0] exp2_lut_data_out,
    output logic                 load_done,
`ifdef LOG_MUL_FEEDER_LUT_CHECKSUM_EN
    input  logic [15:0]          lut_checksum,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] in_a,
    input  logic [FLOAT_LEN-1:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [FLOAT_LEN-1:0] mul_a,
    output logic [FLOAT_LEN-1:0] mul_b,
    input  logic [FLOAT_LEN-1:0] mul_result,
    output logic                 out_valid,
    output logic [FLOAT_LEN-1:0] out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 lut_err
);

    localparam int CNT_W = $clog2(LUT_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               beat;
    logic               last_beat;
    logic               accept;
    logic               run_ok;
    logic [MUL_LAT:0]   vld_pipe;
    logic [TAG_W-1:0]   tag_pipe [MUL_LAT+1];

    assign beat      = src_valid && src_ready;
    assign last_beat = beat && (cnt == CNT_W'(LUT_SIZE - 1));
    assign accept    = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first in every always_comb so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_start) state_next = LOAD;
            LOAD:    if (last_beat)  state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready = 1'b0;
        in_ready  = 1'b0;
        load_done = 1'b0;
        case (state)
            LOAD: src_ready = 1'b1;
            RUN: begin
                load_done = 1'b1;
                in_ready  = run_ok;
            end
            default: ;
        endcase
    end

    // LUT write port: one registered strobe per accepted beat, data held between beats.
    // NOTE: data registers are reset too, since they drive module outputs that must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt               <= '0;
            lut_wr_en         <= 1'b0;
            log2_lut_data_out <= '0;
            exp2_lut_data_out <= '0;
        end else begin
            lut_wr_en <= beat;
            if (beat) begin
                cnt               <= cnt + 1'b1;
                log2_lut_data_out <= src_log2;
                exp2_lut_data_out <= src_exp2;
            end
        end
    end

`ifdef LOG_MUL_FEEDER_LUT_CHECKSUM_EN
    logic [15:0] csum;
    logic [15:0] csum_next;
    logic        err_q;

    assign csum_next = csum + 16'(src_log2) + 16'(src_exp2);

    // The final beat's contribution is folded in on the same edge that enters RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            if (beat) csum <= csum_next;
            if (last_beat && (csum_next != lut_checksum)) err_q <= 1'b1;
        end
    end

    assign lut_err = err_q;
    assign run_ok  = !err_q;
`else
    assign lut_err = 1'b0;
    assign run_ok  = 1'b1;
`endif

    // Operand registers carry zero in cycles with no issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            mul_a <= accept ? in_a : '0;
            mul_b <= accept ? in_b : '0;
        end
    end

    // Valid/tag shadow of the multiplier pipeline; entry MUL_LAT lines up with mul_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i <= MUL_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[MUL_LAT-1:0], accept};
            tag_pipe[0] <= in_tag;
            for (int i = 1; i <= MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign out_valid  = vld_pipe[MUL_LAT];
    assign out_tag    = tag_pipe[MUL_LAT];
    assign out_result = mul_result;

endmodule

// File: tb/tb_log_mul_feeder.sv
// Directed self-checking bench for log_mul_feeder: LUT loading, operand issue, tag pipeline and reset behaviour.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_log_mul_feeder;

    localparam int FLOAT_LEN = 16;
    localparam int MANT_LEN  = 10;
    localparam int LUT_SIZE  = 128;
    localparam int MUL_LAT   = 4;
    localparam int TAG_W     = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 load_start;
    logic                 src_valid;
    logic                 src_ready;
    logic [MANT_LEN-1:0]  src_log2;
    logic [FLOAT_LEN-1:0] src_exp2;
    logic                 lut_wr_en;
    logic [MANT_LEN-1:0]  log2_lut_data_out;
    logic [FLOAT_LEN-1:0] exp2_lut_data_out;
    logic                 load_done;
    logic [15:0]          lut_checksum;
    logic                 in_valid;
    logic                 in_ready;
    logic [FLOAT_LEN-1:0] in_a;
    logic [FLOAT_LEN-1:0] in_b;
    logic [TAG_W-1:0]     in_tag;
    logic [FLOAT_LEN-1:0] mul_a;
    logic [FLOAT_LEN-1:0] mul_b;
    logic [FLOAT_LEN-1:0] mul_result;
    logic                 out_valid;
    logic [FLOAT_LEN-1:0] out_result;
    logic [TAG_W-1:0]     out_tag;
    logic                 lut_err;

    int vectors = 0;
    int errors  = 0;
    int beats;

    always #5 clk = ~clk;

    log_mul_feeder #(
        .FLOAT_LEN(FLOAT_LEN), .MANT_LEN(MANT_LEN), .LUT_SIZE(LUT_SIZE),
        .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_start(load_start),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_log2(src_log2),
        .src_exp2(src_exp2),
        .lut_wr_en(lut_wr_en),
        .log2_lut_data_out(log2_lut_data_out),
        .exp2_lut_data_out(exp2_lut_data_out),
        .load_done(load_done),
`ifdef LOG_MUL_FEEDER_LUT_CHECKSUM_EN
        .lut_checksum(lut_checksum),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_tag(in_tag),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_result(mul_result),
        .out_valid(out_valid),
        .out_result(out_result),
        .out_tag(out_tag),
        .lut_err(lut_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // 128 back-to-back beats with log2=i, exp2=3C00+i; checks every strobe and the hand-off to RUN.
    task automatic load_b2b();
        for (int i = 0; i < LUT_SIZE; i++) begin
            src_valid = 1'b1;
            src_log2  = MANT_LEN'(i);
            src_exp2  = 16'h3C00 + 16'(i);
            step();
            check("b2b_wr_en", 32'(lut_wr_en), 32'd1);
            check("b2b_log2", 32'(log2_lut_data_out), 32'(i));
            check("b2b_exp2", 32'(exp2_lut_data_out), 32'h3C00 + 32'(i));
            check("b2b_load_done", 32'(load_done), 32'(i == LUT_SIZE - 1));
            check("b2b_src_ready", 32'(src_ready), 32'(i != LUT_SIZE - 1));
        end
        src_valid = 1'b0;
        step();
        check("b2b_wr_en_after", 32'(lut_wr_en), 32'd0);
        check("b2b_done_after", 32'(load_done), 32'd1);
        check("b2b_src_ready_after", 32'(src_ready), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        load_start   = 1'b0;
        src_valid    = 1'b0;
        src_log2     = '0;
        src_exp2     = '0;
        lut_checksum = 16'h3F80;  // sum of i + (3C00+i) over 128 entries, mod 2^16
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_tag       = '0;
        mul_result   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_wr_en", 32'(lut_wr_en), 32'd0);
        check("rst_log2", 32'(log2_lut_data_out), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_lut_err", 32'(lut_err), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_src_ready", 32'(src_ready), 32'd0);

        // Back-to-back load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load_src_ready", 32'(src_ready), 32'd1);
        check("load_wr_en_idle", 32'(lut_wr_en), 32'd0);
        check("load_in_ready", 32'(in_ready), 32'd0);
        load_b2b();
        check("run_in_ready", 32'(in_ready), 32'd1);
        check("run_lut_err", 32'(lut_err), 32'd0);

        // Single operation, tag 3
        in_valid   = 1'b1;
        in_a       = 16'h3C00;
        in_b       = 16'h4000;
        in_tag     = 4'd3;
        mul_result = 16'h4000;
        step();
        in_valid = 1'b0;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_tag   = 4'd9;
        check("op_mul_a", 32'(mul_a), 32'h3C00);
        check("op_mul_b", 32'(mul_b), 32'h4000);
        check("op_out_result", 32'(out_result), 32'h4000);
        check("op_out_valid_0", 32'(out_valid), 32'd0);
        for (int j = 1; j < 9; j++) begin
            step();
            check("op_mul_a_idle", 32'(mul_a), 32'd0);
            check("op_mul_b_idle", 32'(mul_b), 32'd0);
            check("op_out_valid", 32'(out_valid), 32'(j == MUL_LAT));
            if (j == MUL_LAT) check("op_out_tag", 32'(out_tag), 32'd3);
        end

        // Back-to-back pairs, tags 0..7
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_tag   = TAG_W'(c);
            in_a     = 16'h0100 + 16'(c);
            in_b     = 16'h0200 + 16'(c);
            step();
            check("b2b_op_mul_a", 32'(mul_a), (c < 8) ? 32'h0100 + 32'(c) : 32'd0);
            check("b2b_op_valid", 32'(out_valid), 32'(c >= MUL_LAT && c < 8 + MUL_LAT));
            if (c >= MUL_LAT && c < 8 + MUL_LAT)
                check("b2b_op_tag", 32'(out_tag), 32'(c - MUL_LAT));
        end

        // Reset after 60 beats of a fresh load
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            src_valid = 1'b1;
            src_log2  = MANT_LEN'(i);
            src_exp2  = 16'h7000;
            step();
        end
        check("mid_wr_en", 32'(lut_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_load_done", 32'(load_done), 32'd0);
        check("mid_rst_src_ready", 32'(src_ready), 32'd0);
        check("mid_rst_wr_en", 32'(lut_wr_en), 32'd0);
        check("mid_rst_log2", 32'(log2_lut_data_out), 32'd0);
        src_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Toggled load with in_valid held high during IDLE/LOAD: 128 fresh beats required
        in_valid = 1'b1;
        in_a     = 16'h5555;
        in_b     = 16'hAAAA;
        in_tag   = 4'd5;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_mul_a", 32'(mul_a), 32'd0);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 256; cyc++) begin
            src_valid = (cyc % 2 == 0);
            src_log2  = MANT_LEN'(beats);
            src_exp2  = 16'h3C00 + 16'(beats);
            in_valid  = (beats < LUT_SIZE);
            step();
            if (cyc % 2 == 0) beats++;
            check("tog_wr_en", 32'(lut_wr_en), 32'(cyc % 2 == 0));
            if (cyc % 2 == 0) begin
                check("tog_log2", 32'(log2_lut_data_out), 32'(beats - 1));
                check("tog_exp2", 32'(exp2_lut_data_out), 32'h3C00 + 32'(beats - 1));
            end
            check("tog_load_done", 32'(load_done), 32'(beats == LUT_SIZE));
            check("tog_src_ready", 32'(src_ready), 32'(beats < LUT_SIZE));
            check("tog_in_ready", 32'(in_ready), 32'(beats == LUT_SIZE));
            check("tog_mul_a", 32'(mul_a), 32'd0);
            check("tog_out_valid", 32'(out_valid), 32'd0);
        end
        src_valid = 1'b0;
        in_valid  = 1'b0;

        // load_start in RUN is ignored
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        step();
        check("run_start_load_done", 32'(load_done), 32'd1);
        check("run_start_src_ready", 32'(src_ready), 32'd0);
        check("run_start_in_ready", 32'(in_ready), 32'd1);
        check("run_start_wr_en", 32'(lut_wr_en), 32'd0);

`ifdef LOG_MUL_FEEDER_LUT_CHECKSUM_EN
        // Wrong checksum: sticky error and operands blocked
        rst_n = 1'b0;
        step();
        rst_n        = 1'b1;
        lut_checksum = 16'h1234;
        load_start   = 1'b1;
        step();
        load_start = 1'b0;
        load_b2b();
        check("cs_lut_err", 32'(lut_err), 32'd1);
        check("cs_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_a     = 16'h3C00;
        for (int j = 0; j < 8; j++) begin
            step();
            check("cs_mul_a", 32'(mul_a), 32'd0);
            check("cs_out_valid", 32'(out_valid), 32'd0);
            check("cs_err_sticky", 32'(lut_err), 32'd1);
        end
        in_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/log_mul_feeder.md
Name: log_mul_feeder

Overview:
- Upstream control and issue stage for the log-scale float16 multiplier.
- After a start pulse, accepts exactly LUT_SIZE log2/exp2 table beats from a streaming source and drives them onto the multiplier's sequential LUT write port.
- Once loading is complete, accepts float16 operand pairs through a valid/ready handshake and registers them onto the multiplier a/b inputs.
- Tracks the multiplier's fixed pipeline latency and presents each result with a valid flag and its matching tag.

Parameters:
- FLOAT_LEN, 16, float word width.
- MANT_LEN, 10, log2 LUT entry width.
- LUT_SIZE, 128, number of entries per table.
- MUL_LAT, 4, multiplier latency: cycles from its a/b inputs being sampled to the result register updating.
- TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle pulse that begins LUT loading
- src_valid  in  1  LUT source beat valid
- src_ready  out  1  LUT source beat accepted
- src_log2  in  MANT_LEN  log2 entry
- src_exp2  in  FLOAT_LEN  exp2 entry
- lut_wr_en  out  1  to multiplier, write strobe
- log2_lut_data_out  out  MANT_LEN  to multiplier
- exp2_lut_data_out  out  FLOAT_LEN  to multiplier
- load_done  out  1  high once all LUT_SIZE entries are written
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted
- in_a, in_b  in  FLOAT_LEN  operands
- in_tag  in  TAG_W  user tag
- mul_a, mul_b  out  FLOAT_LEN  to multiplier a/b
- mul_result  in  FLOAT_LEN  from multiplier result
- out_valid  out  1  result valid
- out_result  out  FLOAT_LEN  equals mul_result
- out_tag  out  TAG_W  tag aligned with out_result
- lut_err  out  1  checksum mismatch (only with the optional feature)

Behaviour:
- **Reset and interface.** Reset is rst_n, asynchronous, active-low; the clock is clk.
- **Reset values.** All outputs reset to 0 and the FSM resets to IDLE. The entry counter cnt is $clog2(LUT_SIZE)+1 bits and resets to 0.
- **FSM states:**
  - IDLE: src_ready=0, in_ready=0. load_start moves to LOAD.
  - LOAD: src_ready=1. On each beat (src_valid&&src_ready):
    - lut_wr_en, log2_lut_data_out and exp2_lut_data_out are registered, so the strobe appears one cycle after acceptance and lasts one cycle per beat.
    - cnt increments.
    - When the beat accepted with cnt==LUT_SIZE-1 completes, the FSM moves to RUN and src_ready drops in the same edge.
    - Gaps in src_valid produce gaps in lut_wr_en; no write happens without a beat.
  - RUN: load_done=1, src_ready=0, in_ready=1. RUN is terminal; leaving it requires rst_n, because the multiplier's write pointer only clears on reset.
- **load_start outside IDLE.** Ignored.
- **Operand issue.**
  - On acceptance (in_valid&&in_ready), mul_a/mul_b are registered from in_a/in_b.
  - In cycles with no acceptance, mul_a/mul_b are driven to 16'h0000.
  - Each operation occupies one cycle; full throughput is one pair per cycle.
- **Valid/tag pipeline.**
  - The valid/tag shift register has MUL_LAT+1 entries. Entry 0 loads {accept, in_tag} at the acceptance edge, and all entries shift every cycle.
  - out_valid is entry MUL_LAT and out_tag is that entry's tag.
  - A pair accepted at edge k yields out_valid high for exactly the cycle after edge k+MUL_LAT (5 cycles after acceptance at the defaults).
  - out_result passes mul_result through combinationally.
- **Backpressure.** There is no downstream backpressure; the consumer must take out_valid beats every cycle.
- **Operands outside RUN.** in_valid while not in RUN is ignored; no operand is captured.
- **Reset mid-load or mid-flight.** Returns to IDLE, clears cnt and the valid pipe, and drops every valid in flight. The multiplier is reset by the same rst_n.

Optional Feature:
- Macro: LOG_MUL_FEEDER_LUT_CHECKSUM_EN.
- **Defined:**
  - A 16-bit accumulator sums src_log2 (zero-extended) plus src_exp2 for every accepted beat, wrapping mod 2^16.
  - On entering RUN it is compared with an extra input port lut_checksum[15:0]. If they differ, lut_err is set and sticky until reset, and in_ready is held 0 in RUN.
- **Not defined:** no accumulator and no lut_checksum port; lut_err is tied to 0.

Test Plan:
- Reset then load_start, then 128 back-to-back beats where entry i has src_log2=i and src_exp2=16'h3C00+i:
  - lut_wr_en is high for exactly 128 consecutive cycles, the first one cycle after the first acceptance, with data matching i.
  - load_done rises the cycle after the 128th acceptance, and src_ready is 0 from then on.
- Load with src_valid toggling every other cycle:
  - exactly 128 write strobes, each paired with correct data; load_done only after the 128th.
- After load, issue a=16'h3C00, b=16'h4000, tag=3 at edge k:
  - mul_a=16'h3C00 and mul_b=16'h4000 for one cycle.
  - out_valid and out_tag=3 appear in the cycle after edge k+4.
  - No other out_valid pulses.
- Back-to-back pairs with tags 0..7 over 8 cycles:
  - 8 consecutive out_valid cycles, tags in order 0..7.
- Assert rst_n low after 60 load beats, then restart:
  - load_done=0, cnt restarts, and 128 fresh beats are required.
- in_valid held high during IDLE/LOAD and load_start pulsed in RUN:
  - in_ready stays 0 until RUN, and no state change occurs.
  - With LOG_MUL_FEEDER_LUT_CHECKSUM_EN and a wrong lut_checksum: lut_err=1 and in_ready stays 0.
